// File: rtl/wb_trace_buffer.sv
// Trace buffer that captures retired writeback values from the core into a
// show-ahead FIFO, with drop counting and an optional halt on the first drop.
module wb_trace_buffer #(
  parameter int DW           = 32,
  parameter int DEPTH        = 16,
  parameter int STOP_ON_FULL = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_valid,
  input  logic [DW-1:0]            WB_Data,
  input  logic                     capture_en,
  input  logic                     clear,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [DW-1:0]            rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic [1:0]               state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic [15:0]     r_drop_cnt;

  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_count != '0) && rd_ready;
  assign w_push = (r_state == CAPTURE) && wb_valid && (!w_full || w_pop);
  assign w_drop = (r_state == CAPTURE) && wb_valid && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_state    <= IDLE;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      case (r_state)
        IDLE:    if (capture_en) r_state <= CAPTURE;
        CAPTURE: begin
          if (w_drop && (STOP_ON_FULL != 0)) r_state <= HALT;
          else if (!capture_en)              r_state <= IDLE;
        end
        HALT:    r_state <= HALT;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Storage needs no reset; pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !clear && !reset) r_mem[r_wptr] <= WB_Data;
  end

  assign rd_valid = (r_count != '0);
  assign rd_data  = (reset || !rd_valid) ? '0 : r_mem[r_rptr];
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;
  assign state    = r_state;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer: a vector table for basic FIFO
// behaviour plus hand sequences for full/drop/clear/reset, with a data scoreboard.
module tb_wb_trace_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          wbValid;
  logic [DW-1:0] wbData;
  logic          captureEn;
  logic          clearIn;
  logic          rdReady;

  logic          rdValidA, rdValidB;
  logic [DW-1:0] rdDataA, rdDataB;
  logic [4:0]    countA, countB;
  logic          overflowA, overflowB;
  logic [15:0]   dropCntA, dropCntB;
  logic [1:0]    stateA, stateB;

  int total = 0;
  int bad   = 0;
  logic [31:0] expQ [$];

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        en;
    logic        rdy;
    logic [4:0]  expCount;
    logic        expValid;
    logic [31:0] expData;
    logic [1:0]  expState;
  } vec_t;

  vec_t vecs [15];

  wb_trace_buffer #(.DW(DW), .DEPTH(DEPTH), .STOP_ON_FULL(1)) dutHalt (
    .clk(clk), .reset(reset), .wb_valid(wbValid), .WB_Data(wbData),
    .capture_en(captureEn), .clear(clearIn), .rd_ready(rdReady),
    .rd_valid(rdValidA), .rd_data(rdDataA), .count(countA),
    .overflow(overflowA), .drop_cnt(dropCntA), .state(stateA)
  );

  wb_trace_buffer #(.DW(DW), .DEPTH(DEPTH), .STOP_ON_FULL(0)) dutKeep (
    .clk(clk), .reset(reset), .wb_valid(wbValid), .WB_Data(wbData),
    .capture_en(captureEn), .clear(clearIn), .rd_ready(rdReady),
    .rd_valid(rdValidB), .rd_data(rdDataB), .count(countB),
    .overflow(overflowB), .drop_cnt(dropCntB), .state(stateB)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [31:0] d, input logic en,
                               input logic rdy, input logic clr);
    wbValid   = v;
    wbData    = d;
    captureEn = en;
    rdReady   = rdy;
    clearIn   = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Compare the show-ahead head against the scoreboard, then pop it.
  task automatic popCheck(input string name);
    if (expQ.size() == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL %s: got empty scoreboard want entry", name);
    end else begin
      checkOutput(name, rdDataA, expQ.pop_front());
    end
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 2'd1};
    vecs[1]  = '{1'b1, 32'd1, 1'b1, 1'b0, 5'd1, 1'b1, 32'd1, 2'd1};
    vecs[2]  = '{1'b1, 32'd2, 1'b1, 1'b0, 5'd2, 1'b1, 32'd1, 2'd1};
    vecs[3]  = '{1'b1, 32'd3, 1'b1, 1'b0, 5'd3, 1'b1, 32'd1, 2'd1};
    vecs[4]  = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 1'b1, 32'd2, 2'd1};
    vecs[5]  = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 1'b1, 32'd3, 2'd1};
    vecs[6]  = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 2'd1};
    vecs[7]  = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 2'd1};
    vecs[8]  = '{1'b0, 32'd0, 1'b0, 1'b0, 5'd0, 1'b0, 32'd0, 2'd0};
    vecs[9]  = '{1'b1, 32'd9, 1'b1, 1'b0, 5'd0, 1'b0, 32'd0, 2'd1};
    vecs[10] = '{1'b1, 32'd5, 1'b1, 1'b1, 5'd1, 1'b1, 32'd5, 2'd1};
    vecs[11] = '{1'b1, 32'd6, 1'b1, 1'b1, 5'd1, 1'b1, 32'd6, 2'd1};
    vecs[12] = '{1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 1'b0, 32'd0, 2'd1};
    vecs[13] = '{1'b1, 32'd7, 1'b0, 1'b0, 5'd1, 1'b1, 32'd7, 2'd0};
    vecs[14] = '{1'b1, 32'd8, 1'b0, 1'b1, 5'd0, 1'b0, 32'd0, 2'd0};

    reset     = 1'b1;
    wbValid   = 1'b0;
    wbData    = '0;
    captureEn = 1'b0;
    clearIn   = 1'b0;
    rdReady   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset state",    32'(stateA),    32'd0);
    checkOutput("reset count",    32'(countA),    32'd0);
    checkOutput("reset rd_valid", 32'(rdValidA),  32'd0);
    checkOutput("reset rd_data",  rdDataA,        32'd0);
    checkOutput("reset overflow", 32'(overflowA), 32'd0);
    checkOutput("reset drop_cnt", 32'(dropCntA),  32'd0);
    reset = 1'b0;

    // Basic capture, in-order drain, and push/pop interplay near empty.
    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].en, vecs[i].rdy, 1'b0);
      checkOutput($sformatf("vec%0d count", i),    32'(countA),   32'(vecs[i].expCount));
      checkOutput($sformatf("vec%0d rd_valid", i), 32'(rdValidA), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d state", i),    32'(stateA),   32'(vecs[i].expState));
      if (vecs[i].expValid)
        checkOutput($sformatf("vec%0d rd_data", i), rdDataA, vecs[i].expData);
    end

    // Writebacks while disabled must be ignored entirely.
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 32'(i + 40), 1'b0, 1'b0, 1'b0);
    checkOutput("idle count",    32'(countA),   32'd0);
    checkOutput("idle drop_cnt", 32'(dropCntA), 32'd0);
    checkOutput("idle state",    32'(stateA),   32'd0);

    // Fill to DEPTH, then a push with a same-cycle pop at full.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0, 1'b0);
      expQ.push_back(32'h100 + 32'(i));
    end
    checkOutput("full count",    32'(countA),    32'd16);
    checkOutput("full overflow", 32'(overflowA), 32'd0);
    checkOutput("full head",     rdDataA,        32'h100);

    checkOutput("pushpop head", rdDataA, expQ.pop_front());
    expQ.push_back(32'hAA);
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b1, 1'b0);
    checkOutput("pushpop count",    32'(countA),   32'd16);
    checkOutput("pushpop drop_cnt", 32'(dropCntA), 32'd0);
    checkOutput("pushpop state",    32'(stateA),   32'd1);

    // First drop halts one instance; the other keeps counting drops.
    applyStimulus(1'b1, 32'hBB, 1'b1, 1'b0, 1'b0);
    checkOutput("drop1 drop_cnt", 32'(dropCntA),  32'd1);
    checkOutput("drop1 overflow", 32'(overflowA), 32'd1);
    checkOutput("drop1 state",    32'(stateA),    32'd2);
    checkOutput("drop1 count",    32'(countA),    32'd16);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'hCC, 1'b1, 1'b0, 1'b0);
    checkOutput("halt drop_cnt",  32'(dropCntA),  32'd1);
    checkOutput("halt state",     32'(stateA),    32'd2);
    checkOutput("keep drop_cnt",  32'(dropCntB),  32'd4);
    checkOutput("keep state",     32'(stateB),    32'd1);
    checkOutput("keep overflow",  32'(overflowB), 32'd1);
    checkOutput("keep count",     32'(countB),    32'd16);

    // Drain across the pointer wrap; the pushed-at-full 0xAA must come out last.
    for (int i = 0; i < DEPTH; i++) popCheck($sformatf("drain%0d", i));
    checkOutput("drained count",    32'(countA),   32'd0);
    checkOutput("drained rd_valid", 32'(rdValidA), 32'd0);
    checkOutput("drained state",    32'(stateA),   32'd2);

    // Clear wins over a simultaneous push and pop.
    applyStimulus(1'b1, 32'hDD, 1'b1, 1'b1, 1'b1);
    checkOutput("clear state",    32'(stateA),    32'd0);
    checkOutput("clear overflow", 32'(overflowA), 32'd0);
    checkOutput("clear drop_cnt", 32'(dropCntA),  32'd0);
    checkOutput("clear count B",  32'(countB),    32'd0);
    checkOutput("clear state B",  32'(stateB),    32'd0);
    checkOutput("clear drop B",   32'(dropCntB),  32'd0);

    // Asynchronous reset in the middle of a cycle with entries stored.
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b1, 1'b0, 1'b0);
    checkOutput("prereset count", 32'(countA), 32'd5);
    wbValid   = 1'b0;
    captureEn = 1'b0;
    #2 reset  = 1'b1;
    #1;
    checkOutput("async count",    32'(countA),   32'd0);
    checkOutput("async rd_valid", 32'(rdValidA), 32'd0);
    checkOutput("async rd_data",  rdDataA,       32'd0);
    checkOutput("async state",    32'(stateA),   32'd0);
    #2 reset = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
    checkOutput("resume count", 32'(countA), 32'd1);
    checkOutput("resume data",  rdDataA,     32'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DW, default 32, meaning writeback data width.
REQ-002 SHALL have parameter DEPTH, default 16, meaning FIFO entries (power of two, >=2).
REQ-003 SHALL have parameter STOP_ON_FULL, default 1, meaning 1 halts capture on first drop and 0 keeps capturing.
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1, meaning asynchronous active-high reset.
REQ-006 SHALL have port wb_valid, input, 1, meaning wb_data carries a retired writeback value this cycle.
REQ-007 SHALL have port WB_Data, input, DW, meaning writeback value from the riscv core.
REQ-008 SHALL have port capture_en, input, 1, meaning level enable for capture.
REQ-009 SHALL have port clear, input, 1, meaning synchronous one-cycle flush and re-arm.
REQ-010 SHALL have port rd_ready, input, 1, meaning consumer accepts rd_data this cycle.
REQ-011 SHALL have port rd_valid, output, 1, meaning rd_data holds the oldest entry.
REQ-012 SHALL have port rd_data, output, DW, meaning oldest captured value (show-ahead).
REQ-013 SHALL have port count, output, log2(DEPTH)+1, meaning current occupancy.
REQ-014 SHALL have port overflow, output, 1, meaning sticky flag set on first dropped value.
REQ-015 SHALL have port drop_cnt, output, 16, meaning dropped values, saturating at 16'hFFFF.
REQ-016 SHALL have port state, output, 2, meaning FSM state encoding IDLE=0, CAPTURE=1, HALT=2.

Function
REQ-017 SHALL implement FSM states IDLE, CAPTURE, HALT; IDLE->CAPTURE when capture_en=1; CAPTURE->IDLE when capture_en=0.
REQ-018 SHALL transition CAPTURE->HALT when a drop occurs and STOP_ON_FULL=1; HALT exits only via clear (-> IDLE).
REQ-019 SHALL push WB_Data when state=CAPTURE and wb_valid=1 and (count<DEPTH or a pop occurs in the same cycle).
REQ-020 SHALL count a drop when state=CAPTURE, wb_valid=1, count=DEPTH and no same-cycle pop; value discarded, FIFO unchanged.
REQ-021 SHALL ignore wb_valid in IDLE and HALT (no push, no drop count).
REQ-022 SHALL pop when rd_valid=1 and rd_ready=1; rd_ready with rd_valid=0 has no effect.
REQ-023 SHALL drive rd_valid = (count!=0) and rd_data = head entry combinationally from registered storage; push-to-rd_valid latency one cycle.
REQ-024 SHALL hold rd_data stable while rd_valid=1 and rd_ready=0.
REQ-025 SHALL update count +1 on push-only, -1 on pop-only, unchanged on simultaneous push and pop.
REQ-026 SHALL wrap read/write pointers modulo DEPTH.
REQ-027 SHALL on simultaneous push and pop at count=DEPTH accept the push; no drop.
REQ-028 SHALL on simultaneous push and pop at count=0 not pop (rd_valid was 0); push lands, count=1.
REQ-029 SHALL set overflow on the first drop and hold it until clear or reset; drop_cnt saturates, never wraps.
REQ-030 SHALL on clear empty the FIFO, zero count, overflow, drop_cnt, go to IDLE; clear has priority over push/pop in that cycle.

Reset
REQ-031 SHALL on reset assertion immediately (asynchronously) force state=IDLE, pointers=0, count=0, rd_valid=0, overflow=0, drop_cnt=0.
REQ-032 SHALL force rd_data to 0 during reset; reset mid-capture discards all stored entries.
REQ-033 SHALL resume operation on the first rising clk edge after reset deasserts.

Verification
REQ-034 SHALL verify: capture_en=1, wb_valid for values 1,2,3, rd_ready=0 -> count=3, rd_data=1; then rd_ready=1 three cycles -> rd_data 1,2,3, count=0, rd_valid=0.
REQ-035 SHALL verify: DEPTH=16, 18 pushes, no reads, STOP_ON_FULL=1 -> count=16, drop_cnt=1, overflow=1, state=HALT after 17th; 18th ignored.
REQ-036 SHALL verify: count=16, push 0xAA and pop same cycle -> count=16, drop_cnt=0, tail entry=0xAA.
REQ-037 SHALL verify: STOP_ON_FULL=0, 20 pushes into empty 16-deep FIFO -> drop_cnt=4, state=CAPTURE; then clear -> count=0, overflow=0, state=IDLE.
REQ-038 SHALL verify: reset asserted mid-cycle with count=5 -> rd_valid=0, count=0 before next clk edge; capture resumes after deassertion.
REQ-039 SHALL verify: capture_en=0 with wb_valid=1 for 10 cycles -> count=0, drop_cnt=0.
